// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation controller: state encoding,
// parameter defaults and a small compile-time helper.
package me_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COLD   = 3'd1,
        ST_FILL   = 3'd2,
        ST_SEARCH = 3'd3,
        ST_NEXT   = 3'd4,
        ST_LOAD   = 3'd5,
        ST_DONE   = 3'd6
    } me_state_t;

    localparam int NUM_BLOCKS_DEF   = 16;
    localparam int SEARCH_LINES_DEF = 23;
    localparam int CUR_BURST_DEF    = 8;
    localparam int COLD_BLOCKS_DEF  = 2;
    localparam int CNT_W            = 16;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/me_cnt.sv
// Loadable down-counter that saturates at zero and flags terminal count.
module me_cnt
    import me_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count_r;

    // Count register: load has priority over decrement, never wraps below zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {W{1'b0}})) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == {W{1'b0}});

endmodule

// File: rtl/me_ctrl.sv
// Motion-estimation sequencing controller: preloads current blocks, then per
// block waits for the reference window, sweeps search lines and loads the next block.
module me_ctrl
    import me_pkg::*;
#(
    parameter int NUM_BLOCKS   = NUM_BLOCKS_DEF,
    parameter int SEARCH_LINES = SEARCH_LINES_DEF,
    parameter int CUR_BURST    = CUR_BURST_DEF,
    parameter int COLD_BLOCKS  = COLD_BLOCKS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sram_ready,
    output logic       need_cur,
    output logic       need_ref,
    output logic       cur_read_en,
    output logic       cur_read_start,
    output logic       cur_next_block,
    output logic       ref_next_line,
    output logic       busy,
    output logic       done,
    output logic [7:0] blk_idx,
    output logic [4:0] line_idx
);

    localparam int               COLD_N      = min_int(COLD_BLOCKS, NUM_BLOCKS);
    localparam logic [CNT_W-1:0] COLD_LEN    = CNT_W'(CUR_BURST * COLD_N - 1);
    localparam logic [CNT_W-1:0] BURST_LEN   = CNT_W'(CUR_BURST - 1);
    localparam logic [CNT_W-1:0] LINE_LEN    = CNT_W'(SEARCH_LINES - 1);
    localparam logic [7:0]       LAST_BLK    = 8'(NUM_BLOCKS - 1);
    localparam logic [7:0]       COLD_LOADED = 8'(COLD_N);
    localparam logic [7:0]       TOTAL_BLKS  = 8'(NUM_BLOCKS);
    localparam logic [4:0]       LAST_LINE   = 5'(SEARCH_LINES - 1);

    me_state_t          state_r, state_s;
    logic [7:0]         blk_r, loaded_r;
    logic [4:0]         line_r;
    logic               burst_load_s, line_load_s, burst_tc_s, line_tc_s;
    logic [CNT_W-1:0]   burst_val_s;
    logic               last_blk_s, more_s;

    assign last_blk_s = (blk_r == LAST_BLK);
    assign more_s     = (loaded_r < TOTAL_BLKS);

    me_cnt #(.W(CNT_W)) u_burst_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (burst_load_s),
        .load_val (burst_val_s),
        .dec      ((state_r == ST_COLD) || (state_r == ST_LOAD)),
        .tc       (burst_tc_s)
    );

    me_cnt #(.W(CNT_W)) u_line_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (line_load_s),
        .load_val (LINE_LEN),
        .dec      (state_r == ST_SEARCH),
        .tc       (line_tc_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and timer loads; timers are armed on the entering transition.
    always_comb begin
        state_s      = state_r;
        burst_load_s = 1'b0;
        burst_val_s  = BURST_LEN;
        line_load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s      = ST_COLD;
                    burst_load_s = 1'b1;
                    burst_val_s  = COLD_LEN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COLD: begin
                if (burst_tc_s) state_s = ST_FILL;
                else            state_s = ST_COLD;
            end
            ST_FILL: begin
                if (sram_ready) begin
                    state_s     = ST_SEARCH;
                    line_load_s = 1'b1;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_SEARCH: begin
                if (line_tc_s) state_s = ST_NEXT;
                else           state_s = ST_SEARCH;
            end
            ST_NEXT: begin
                if (last_blk_s) begin
                    state_s = ST_DONE;
                end else if (more_s) begin
                    state_s      = ST_LOAD;
                    burst_load_s = 1'b1;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_LOAD: begin
                if (burst_tc_s) state_s = ST_FILL;
                else            state_s = ST_LOAD;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Block, line and loaded-block bookkeeping; everything clears on the way into IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_r    <= 8'd0;
            line_r   <= 5'd0;
            loaded_r <= 8'd0;
        end else if (state_s == ST_IDLE) begin
            blk_r    <= 8'd0;
            line_r   <= 5'd0;
            loaded_r <= 8'd0;
        end else begin
            case (state_r)
                ST_COLD:   if (burst_tc_s) loaded_r <= COLD_LOADED;
                ST_FILL:   if (sram_ready) line_r <= 5'd0;
                ST_SEARCH: if (line_r != LAST_LINE) line_r <= line_r + 5'd1;
                ST_NEXT:   if (!last_blk_s) blk_r <= blk_r + 8'd1;
                ST_LOAD:   if (burst_tc_s) loaded_r <= loaded_r + 8'd1;
                default:   blk_r <= blk_r;
            endcase
        end
    end

    assign need_cur       = (state_r == ST_COLD) || (state_r == ST_LOAD);
    assign cur_read_en    = need_cur;
    assign need_ref       = (state_r == ST_FILL) || (state_r == ST_SEARCH);
    assign ref_next_line  = (state_r == ST_SEARCH);
    assign cur_next_block = (state_r == ST_NEXT);
    assign cur_read_start = (state_r == ST_NEXT) && !last_blk_s && more_s;
    assign busy           = (state_r != ST_IDLE) && (state_r != ST_DONE);
    assign done           = (state_r == ST_DONE);
    assign blk_idx        = blk_r;
    assign line_idx       = line_r;

endmodule

// File: tb/tb_me_ctrl.sv
// Directed bench for me_ctrl: default-parameter instance plus a single-block instance.
module tb_me_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, sram0 = 1'b0, start1 = 1'b0, sram1 = 1'b0;

    logic nc0, nr0, cre0, crs0, cnb0, rnl0, busy0, done0;
    logic nc1, nr1, cre1, crs1, cnb1, rnl1, busy1, done1;
    logic [7:0] blk0, blk1;
    logic [4:0] line0, line1;

    always #5 clk = ~clk;

    me_ctrl dut0 (
        .clk(clk), .rst(rst), .start(start0), .sram_ready(sram0),
        .need_cur(nc0), .need_ref(nr0), .cur_read_en(cre0), .cur_read_start(crs0),
        .cur_next_block(cnb0), .ref_next_line(rnl0), .busy(busy0), .done(done0),
        .blk_idx(blk0), .line_idx(line0)
    );

    me_ctrl #(.NUM_BLOCKS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sram_ready(sram1),
        .need_cur(nc1), .need_ref(nr1), .cur_read_en(cre1), .cur_read_start(crs1),
        .cur_next_block(cnb1), .ref_next_line(rnl1), .busy(busy1), .done(done1),
        .blk_idx(blk1), .line_idx(line1)
    );

    bit sel = 1'b0;
    wire [20:0] all0 = {nc0, nr0, cre0, crs0, cnb0, rnl0, busy0, done0, blk0, line0};
    wire [20:0] all1 = {nc1, nr1, cre1, crs1, cnb1, rnl1, busy1, done1, blk1, line1};
    wire [20:0] o_all = sel ? all1 : all0;
    wire o_nc = o_all[20], o_nr = o_all[19], o_cre = o_all[18], o_crs = o_all[17];
    wire o_cnb = o_all[16], o_rnl = o_all[15], o_busy = o_all[14], o_done = o_all[13];
    wire [7:0] o_blk = o_all[12:5];
    wire [4:0] o_line = o_all[4:0];

    int checks = 0, failures = 0;
    int cold_cnt, rnl_cnt, cnb_cnt, crs_cnt, cre_cnt, done_cnt, blk_at_done;
    bit aborted, timed_out;

    task automatic drive(input bit st, input bit sr);
        if (sel) begin start1 = st; sram1 = sr; end
        else     begin start0 = st; sram0 = sr; end
    endtask

    // One full run with an sram model answering 5 cycles after each FILL entry.
    task automatic run(input bit s, input bit inj, input bit rst10);
        int fill_cnt = 0;
        bit seen_fill = 1'b0, inj_start = 1'b0, inj_sram = 1'b0, fin = 1'b0;
        bit st, sr;
        sel = s;
        cold_cnt = 0; rnl_cnt = 0; cnb_cnt = 0; crs_cnt = 0; cre_cnt = 0;
        done_cnt = 0; blk_at_done = -1; aborted = 1'b0; timed_out = 1'b0;
        @(negedge clk);
        drive(1'b1, 1'b0);
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            st = 1'b0; sr = 1'b0;
            if (o_nr) seen_fill = 1'b1;
            if (o_nc && !seen_fill) cold_cnt++;
            if (o_cre) cre_cnt++;
            if (o_rnl) rnl_cnt++;
            if (o_cnb) cnb_cnt++;
            if (o_crs) crs_cnt++;
            if (o_nr && !o_rnl) fill_cnt++; else fill_cnt = 0;
            if (fill_cnt == 6) sr = 1'b1;
            if (inj && o_nc && !seen_fill && !inj_sram) begin sr = 1'b1; inj_sram = 1'b1; end
            if (inj && o_rnl && !inj_start) begin st = 1'b1; inj_start = 1'b1; end
            if (o_done) begin done_cnt++; blk_at_done = o_blk; fin = 1'b1; end
            drive(st, sr);
            if (rst10 && o_rnl && o_line == 5'd10) begin
                drive(1'b0, 1'b0);
                rst = 1'b1;
                #1;
                aborted = 1'b1;
                fin = 1'b1;
            end
        end
        drive(1'b0, 1'b0);
        if (!fin) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (all0 !== 21'd0) begin failures++; $display("FAIL reset_dut0 got=%h exp=0", all0); end
        checks++; if (all1 !== 21'd0) begin failures++; $display("FAIL reset_dut1 got=%h exp=0", all1); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (all0 !== 21'd0) begin failures++; $display("FAIL idle_after_reset got=%h exp=0", all0); end
    endtask

    task automatic test_default_run();
        run(1'b0, 1'b0, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL default_timeout got=timeout exp=done"); end
        checks++; if (cold_cnt != 16) begin failures++; $display("FAIL default_cold got=%0d exp=16", cold_cnt); end
        checks++; if (rnl_cnt != 368) begin failures++; $display("FAIL default_rnl got=%0d exp=368", rnl_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL default_done got=%0d exp=1", done_cnt); end
        checks++; if (cnb_cnt != 16) begin failures++; $display("FAIL default_cnb got=%0d exp=16", cnb_cnt); end
        checks++; if (crs_cnt != 14) begin failures++; $display("FAIL default_crs got=%0d exp=14", crs_cnt); end
        checks++; if (cre_cnt != 128) begin failures++; $display("FAIL default_cre got=%0d exp=128", cre_cnt); end
        checks++; if (blk_at_done != 15) begin failures++; $display("FAIL default_blk_final got=%0d exp=15", blk_at_done); end
        @(negedge clk);
        checks++; if (all0 !== 21'd0) begin failures++; $display("FAIL default_back_idle got=%h exp=0", all0); end
    endtask

    task automatic test_single_block();
        run(1'b1, 1'b0, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL single_timeout got=timeout exp=done"); end
        checks++; if (cold_cnt != 8) begin failures++; $display("FAIL single_cold got=%0d exp=8", cold_cnt); end
        checks++; if (rnl_cnt != 23) begin failures++; $display("FAIL single_rnl got=%0d exp=23", rnl_cnt); end
        checks++; if (cnb_cnt != 1) begin failures++; $display("FAIL single_cnb got=%0d exp=1", cnb_cnt); end
        checks++; if (crs_cnt != 0) begin failures++; $display("FAIL single_crs got=%0d exp=0", crs_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL single_done got=%0d exp=1", done_cnt); end
        checks++; if (blk_at_done != 0) begin failures++; $display("FAIL single_blk got=%0d exp=0", blk_at_done); end
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic test_ignored_inputs();
        run(1'b0, 1'b1, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL ignore_timeout got=timeout exp=done"); end
        checks++; if (cold_cnt != 16) begin failures++; $display("FAIL ignore_cold got=%0d exp=16", cold_cnt); end
        checks++; if (rnl_cnt != 368) begin failures++; $display("FAIL ignore_rnl got=%0d exp=368", rnl_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL ignore_done got=%0d exp=1", done_cnt); end
        checks++; if (cnb_cnt != 16) begin failures++; $display("FAIL ignore_cnb got=%0d exp=16", cnb_cnt); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        run(1'b0, 1'b0, 1'b1);
        checks++; if (!aborted) begin failures++; $display("FAIL midrst_reached got=0 exp=1"); end
        checks++; if (all0 !== 21'd0) begin failures++; $display("FAIL midrst_outputs got=%h exp=0", all0); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL midrst_done got=%0d exp=0", done_cnt); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (all0 !== 21'd0) begin failures++; $display("FAIL midrst_idle got=%h exp=0", all0); end
        run(1'b0, 1'b0, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL rerun_timeout got=timeout exp=done"); end
        checks++; if (cold_cnt != 16) begin failures++; $display("FAIL rerun_cold got=%0d exp=16", cold_cnt); end
        checks++; if (rnl_cnt != 368) begin failures++; $display("FAIL rerun_rnl got=%0d exp=368", rnl_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL rerun_done got=%0d exp=1", done_cnt); end
        checks++; if (crs_cnt != 14) begin failures++; $display("FAIL rerun_crs got=%0d exp=14", crs_cnt); end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_single_block();
        test_ignored_inputs();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
